// File: rtl/acc_control_unit.sv
// Multi-cycle FETCH/LATCH/EXEC sequencer driving the data_unit control word from a synchronous ROM.
// Define CU_ILLEGAL_TRAP_EN to halt on opcodes 0xA-0xE and raise illegal_op; otherwise they act as NOP.
module acc_control_unit #(
   parameter logic [7:0] RESET_PC   = 8'h00,
   parameter bit         AUTO_START = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [7:0]  instr_addr,
   input  logic [15:0] instr_data,
   input  logic        zero_flag,
   input  logic        carrier_flag,
   input  logic        negative_flag,
   output logic        load_enable,
   output logic [2:0]  operation_select,
   output logic [1:0]  a_select,
   output logic [1:0]  b_select,
   output logic [1:0]  destination_select,
   output logic [7:0]  constant_in,
   output logic        mb_select,
   output logic        md_select,
   output logic        write_ram_enable,
   output logic        halted,
   output logic        illegal_op
);

   typedef enum logic [2:0] {IDLE, FETCH, LATCH, EXEC, HALT} state_e;

   state_e      state_q, state_d;
   logic [7:0]  pc_q, pc_d;
   logic [15:0] ir_q, ir_d;
   logic        z_q, c_q, n_q;
   logic        z_d, c_d, n_d;

   logic [3:0]  opcode;
   logic [1:0]  fieldDst, fieldA, fieldB;
   logic [7:0]  imm;

   assign opcode   = ir_q[15:12];
   assign fieldDst = ir_q[11:10];
   assign fieldA   = ir_q[9:8];
   assign fieldB   = ir_q[7:6];
   assign imm      = ir_q[7:0];

   assign instr_addr = pc_q;
   assign halted     = (state_q == HALT);

`ifdef CU_ILLEGAL_TRAP_EN
   logic illegalQ, illegalD;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) illegalQ <= 1'b0;
      else        illegalQ <= illegalD;
   end

   assign illegal_op = illegalQ;
`else
   assign illegal_op = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         n_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         z_q     <= z_d;
         c_q     <= c_d;
         n_q     <= n_d;
      end
   end

   always_comb begin
      state_d            = state_q;
      pc_d               = pc_q;
      ir_d               = ir_q;
      z_d                = z_q;
      c_d                = c_q;
      n_d                = n_q;
`ifdef CU_ILLEGAL_TRAP_EN
      illegalD           = illegalQ;
`endif
      load_enable        = 1'b0;
      operation_select   = 3'b000;
      a_select           = 2'b00;
      b_select           = 2'b00;
      destination_select = 2'b00;
      constant_in        = 8'h00;
      mb_select          = 1'b0;
      md_select          = 1'b0;
      write_ram_enable   = 1'b0;

      unique case (state_q)
         IDLE: if (start || AUTO_START) state_d = FETCH;
         FETCH: state_d = LATCH;
         LATCH: begin
            ir_d    = instr_data;
            state_d = EXEC;
         end
         EXEC: begin
            state_d = FETCH;
            pc_d    = pc_q + 8'd1;
            case (opcode)
               4'h0: ;
               4'h1: begin
                  operation_select   = ir_q[2:0];
                  a_select           = fieldA;
                  b_select           = fieldB;
                  destination_select = fieldDst;
                  load_enable        = 1'b1;
               end
               4'h2: begin
                  operation_select   = 3'b100;
                  mb_select          = 1'b1;
                  constant_in        = imm;
                  destination_select = fieldDst;
                  load_enable        = 1'b1;
               end
               4'h3: begin
                  mb_select          = 1'b1;
                  constant_in        = imm;
                  a_select           = fieldA;
                  destination_select = fieldDst;
                  load_enable        = 1'b1;
               end
               4'h4: begin
                  md_select          = 1'b1;
                  a_select           = fieldA;
                  destination_select = fieldDst;
                  load_enable        = 1'b1;
               end
               4'h5: begin
                  write_ram_enable   = 1'b1;
                  a_select           = fieldA;
                  b_select           = fieldB;
               end
               4'h6: pc_d = imm;
               4'h7: if (z_q) pc_d = imm;
               4'h8: if (c_q) pc_d = imm;
               4'h9: if (n_q) pc_d = imm;
               4'hF: begin
                  state_d = HALT;
                  pc_d    = pc_q;
               end
               default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                  state_d  = HALT;
                  pc_d     = pc_q;
                  illegalD = 1'b1;
`endif
               end
            endcase
            // Only value-producing ops refresh the flags that later branches test.
            if (opcode == 4'h1 || opcode == 4'h2 || opcode == 4'h3) begin
               z_d = zero_flag;
               c_d = carrier_flag;
               n_d = negative_flag;
            end
         end
         HALT: begin
            if (start) begin
               pc_d    = RESET_PC;
               z_d     = 1'b0;
               c_d     = 1'b0;
               n_d     = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
               illegalD = 1'b0;
`endif
               state_d = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: doc/acc_control_unit.md
Name: acc_control_unit

Overview:
- Multi-cycle control sequencer that drives the control inputs of the existing data_unit datapath and consumes its zero, carry and negative flags.
- Fetches 16-bit instructions from a synchronous instruction ROM, decodes them and drives one datapath control word per instruction.
- Sequences branches on registered flags.
- Sits between the instruction ROM and data_unit at processor top level.

Parameters:
- RESET_PC, 8'h00: PC value loaded on reset and on restart.
- AUTO_START, 0: 1 = leave IDLE on the first clock after reset without needing start.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low (0 = reset asserted)
- start  input  1  one-cycle run pulse; honoured only in IDLE or HALT
- instr_addr  output  8  ROM address (= PC)
- instr_data  input  16  ROM data, valid one cycle after instr_addr
- zero_flag, carrier_flag, negative_flag  input  1 each  data_unit ALU flags for the current control word
- load_enable  output  1  register-file write
- operation_select  output  3  ALU op
- a_select, b_select, destination_select  output  2 each  register selects
- constant_in  output  8  immediate
- mb_select  output  1  1 = B operand from constant_in
- md_select  output  1  1 = writeback from RAM
- write_ram_enable  output  1  RAM write (address from A, data from B)
- halted  output  1  high in HALT
- illegal_op  output  1  see Optional Feature

Behaviour:
- Reset asserted:
  - State = IDLE, PC = RESET_PC, IR = 0, flag regs Z/C/N = 0.
  - All outputs 0 immediately (asynchronous).
- States:
  - IDLE: start=1 (or AUTO_START) -> FETCH.
  - FETCH: instr_addr = PC; -> LATCH.
  - LATCH: IR <= instr_data; -> EXEC.
  - EXEC: control word decoded combinationally from IR; PC updated at the end of the cycle; -> FETCH, or -> HALT.
  - HALT: start=1 -> PC = RESET_PC, flags cleared, -> FETCH.
- start is ignored in FETCH, LATCH and EXEC.
- instr_addr holds PC in every state.
- Throughput: 3 cycles per instruction.
- Outside EXEC: load_enable = 0, write_ram_enable = 0, all other control outputs 0.
- IR fields: op = IR[15:12], dst = IR[11:10], a = IR[9:8], b = IR[7:6], alu = IR[2:0], imm = IR[7:0].
- Decode (unlisted control outputs are 0):
  - 0x0 NOP.
  - 0x1 ALU: operation_select = alu, dst/a/b from fields, load_enable = 1.
  - 0x2 LDI: operation_select = 100, mb_select = 1, constant_in = imm, destination_select = dst, load_enable = 1.
  - 0x3 ADDI: operation_select = 000, mb_select = 1, constant_in = imm, a/dst from fields, load_enable = 1.
  - 0x4 LD: md_select = 1, a_select = a, destination_select = dst, load_enable = 1.
  - 0x5 ST: write_ram_enable = 1, a_select = a, b_select = b, load_enable = 0.
  - 0x6 JMP: PC <= imm.
  - 0x7 JZ: branch if Z. 0x8 JC: branch if C. 0x9 JN: branch if N.
  - 0xF HLT: -> HALT; PC unchanged.
  - 0xA–0xE: illegal; behaviour per Optional Feature.
- Flags:
  - Z/C/N <= input flags at the end of EXEC for ALU, LDI and ADDI only.
  - All other opcodes hold the flags.
  - Conditional branches test the flag registers, not the live inputs.
- PC:
  - Non-taken and non-branch instructions: PC <= PC + 1, modulo 256 (0xFF wraps to 0x00).
  - Taken branch: PC <= imm. A jump to self is legal (tight loop).
- Reset asserted mid-EXEC: any RAM or register write in progress is aborted, since the enables drop asynchronously.

Optional Feature:
- Macro CU_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in EXEC drives no control outputs, PC is not advanced, state -> HALT, illegal_op = 1. illegal_op stays high until reset or restart via start.
- Undefined: illegal opcodes execute as NOP (PC + 1); illegal_op is tied to 0.

Test Plan:
- Program LDI r0,10; LDI r1,20; ALU r0 = r0 op000 r1; HLT; pulse start:
  - EXEC cycles show constant_in = 10 then 20, mb_select = 1.
  - Third EXEC shows operation_select = 000, mb_select = 0, load_enable = 1.
  - halted rises after 12 cycles.
- ST a = 0, b = 1 -> write_ram_enable = 1 and load_enable = 0 for exactly one cycle.
- LD dst = 1, a = 0 -> md_select = 1, load_enable = 1, destination_select = 01.
- ADDI with zero_flag = 1 in its EXEC, then JZ 0x40 -> PC = 0x40. Repeat with zero_flag = 0 -> PC = previous + 1.
- PC = 0xFF executing NOP -> next instr_addr = 0x00. Pulse start while in FETCH -> no effect.
- Reset asserted during EXEC of ST -> write_ram_enable falls the same instant, PC = RESET_PC. Opcode 0xB:
  - With CU_ILLEGAL_TRAP_EN: halted = 1, illegal_op = 1.
  - Without: PC advances and illegal_op = 0.
